pc_sequencer: RTL

//   Program-counter sequencer for the CPU fetch path. Consumes the instruction

---
 rtl/pc_sequencer_pkg.sv | 9 +
 rtl/pc_sequencer_ret_stack.sv | 60 ++++++
 rtl/pc_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the fetch-path program-counter sequencer.
package pc_sequencer_pkg;

    // Default address width, which matches the decoder's jump-target field.
    localparam int unsigned DefCntrWidth  = 8;
    // Default number of return-address stack entries.
    localparam int unsigned DefStackDepth = 8;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return-address stack with an occupancy pointer. Storage is not reset.
module pc_sequencer_ret_stack #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SP_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  logic [WIDTH-1:0]    push_data,
    output logic [SP_WIDTH-1:0] sp,
    output logic [WIDTH-1:0]    top,
    output logic                full,
    output logic                empty
);

    localparam int unsigned IdxWidth = $clog2(DEPTH);

    logic [SP_WIDTH-1:0] sp_q, sp_d;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                do_push;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_WIDTH'(DEPTH));
    assign do_push = push && !full && !clear;
    // Entries at or above sp are never consumed, so the sp == 0 read is harmless.
    assign top     = mem[IdxWidth'(sp_q - SP_WIDTH'(1))];
    assign sp      = sp_q;

    // Pointer update: clear beats push, push beats pop.
    always_comb begin
        sp_d = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (do_push) begin
            sp_d = sp_q + SP_WIDTH'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_WIDTH'(1);
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage, written at the current pointer on push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[IdxWidth'(sp_q)] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority next-pc mux, sticky stack error flags,
// and a return-address stack for CAL/RET.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned CNTR_WIDTH  = DefCntrWidth,
    parameter int unsigned STACK_DEPTH = DefStackDepth,
    localparam int unsigned SP_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_en,
    input  logic                  rst_f,
    input  logic                  jmp,
    input  logic                  cal_f,
    input  logic                  ret_f,
    input  logic [CNTR_WIDTH-1:0] jmp_addr,
    output logic [CNTR_WIDTH-1:0] pc,
    output logic [SP_WIDTH-1:0]   sp,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  ovf_err,
    output logic                  unf_err
);

    logic [CNTR_WIDTH-1:0] pc_q, pc_d, pc_inc, stack_top;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  push, pop, clear;

    // Wraps modulo 2^CNTR_WIDTH, so the pushed return address wraps too.
    assign pc_inc = pc_q + CNTR_WIDTH'(1);

    pc_sequencer_ret_stack #(
        .DEPTH    (STACK_DEPTH),
        .WIDTH    (CNTR_WIDTH),
        .SP_WIDTH (SP_WIDTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (pc_inc),
        .sp        (sp),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // Next-pc priority mux: soft reset, RET, CAL, JMP, sequential.
    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        if (step_en) begin
            if (!rst_f) begin
                pc_d  = '0;
                ovf_d = 1'b0;
                unf_d = 1'b0;
                clear = 1'b1;
            end else if (jmp && ret_f) begin
                if (!stack_empty) begin
                    pc_d = stack_top;
                    pop  = 1'b1;
                end else begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (jmp && cal_f) begin
                if (!stack_full) begin
                    push = 1'b1;
                    pc_d = jmp_addr;
                end else begin
                    ovf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (jmp) begin
                pc_d = jmp_addr;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // PC and sticky error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc      = pc_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule
